// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: XLEN, NOP encoding, reset PC default,
// buffer sizing and the response-buffer entry layout.
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH       = 2;
  localparam int unsigned CNT_W            = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CREDITS          = 2;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } rsp_t;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_HOLD,
    SEL_FLUSH,
    SEL_BUF,
    SEL_BYPASS
  } out_sel_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_if;
  import fetch_pkg::*;

  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt;
  logic            i_imem_rvalid;
  logic [XLEN-1:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous clear; simultaneous push and pop on a
// full FIFO is legal.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !clr_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = bump(wr_ptr_q);
      if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (do_push && count_q == CW'(DEPTH)) |-> do_pop);

endmodule

// File: rtl/fetch.sv
// Instruction fetch: credit-limited imem requester with in-order tag queue,
// response buffer, flush/drop handling and a registered output to decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_if.master         imem,
  output logic [XLEN-1:0] or_inst,
  output logic [XLEN-1:0] or_pc,
  output logic            or_valid
);

  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, opc_q, opc_d;
  logic            valid_q, valid_d;
  logic [1:0]      drop_q, drop_d;
  logic            hs, rsp_keep, credit_ok, tag_empty, buf_empty, buf_push;
  logic [CNT_W-1:0] tag_cnt, buf_cnt;
  logic [2:0]      inflight;
  logic [XLEN-1:0] tag_pc;
  rsp_t            buf_head;
  out_sel_e        sel;

  // Dropped requests stay counted in flight so credit covers their responses.
  assign inflight  = {1'b0, tag_cnt} + {1'b0, drop_q};
  assign credit_ok = (inflight + {1'b0, buf_cnt}) < 3'(CREDITS);
  assign imem.o_imem_req  = !i_rst && !i_flush && credit_ok;
  assign imem.o_imem_addr = align_word(pc_q);
  assign hs       = imem.o_imem_req && imem.i_imem_gnt;
  assign rsp_keep = imem.i_imem_rvalid && (drop_q == '0);
  assign buf_push = rsp_keep && (sel != SEL_BYPASS);

  assign or_inst  = inst_q;
  assign or_pc    = opc_q;
  assign or_valid = valid_q;

  always_comb begin
    sel = SEL_IDLE;
    if (i_flush)         sel = SEL_FLUSH;
    else if (i_stall)    sel = SEL_HOLD;
    else if (!buf_empty) sel = SEL_BUF;
    else if (rsp_keep)   sel = SEL_BYPASS;
  end

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    if (i_flush) begin
      pc_d   = align_word(i_redirect_pc);
      drop_d = 2'(inflight - 3'(imem.i_imem_rvalid));
    end else begin
      if (hs) pc_d = pc_q + XLEN'(4);
      if (imem.i_imem_rvalid && drop_q != '0) drop_d = drop_q - 2'd1;
    end
    unique case (sel)
      SEL_FLUSH, SEL_IDLE: begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
      SEL_BUF: begin
        inst_d  = buf_head.inst;
        opc_d   = buf_head.pc;
        valid_d = 1'b1;
      end
      SEL_BYPASS: begin
        inst_d  = imem.i_imem_rdata;
        opc_d   = tag_pc;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      inst_q  <= NOP_INST;
      opc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tagq (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (i_flush),
    .push_i  (hs),
    .wdata_i (align_word(pc_q)),
    .pop_i   (rsp_keep),
    .rdata_o (tag_pc),
    .count_o (tag_cnt),
    .empty_o (tag_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(rsp_t))) u_rspbuf (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (i_flush),
    .push_i  (buf_push),
    .wdata_i ({imem.i_imem_rdata, tag_pc}),
    .pop_i   (sel == SEL_BUF),
    .rdata_o (buf_head),
    .count_o (buf_cnt),
    .empty_o (buf_empty)
  );

  a_rvalid_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
    imem.i_imem_rvalid |-> (!tag_empty || drop_q != '0));

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction driven when no valid instruction is presented.
REQ-003 i_clk  input  1  CPU clock, all state on rising edge.
REQ-004 i_rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 i_stall  input  1  downstream decode stall; hold outputs.
REQ-006 i_flush  input  1  redirect request from execute (branch/jump taken).
REQ-007 i_redirect_pc  input  32  new fetch address, sampled when i_flush=1.
REQ-008 o_imem_req  output  1  instruction memory request valid.
REQ-009 o_imem_addr  output  32  word-aligned request address.
REQ-010 i_imem_gnt  input  1  request accepted this cycle (req&gnt = handshake).
REQ-011 i_imem_rvalid  input  1  response valid; responses in request order, >=1 cycle after grant.
REQ-012 i_imem_rdata  input  32  response instruction word.
REQ-013 or_inst  output  32  registered instruction to decode.
REQ-014 or_pc  output  32  registered PC of or_inst.
REQ-015 or_valid  output  1  or_inst/or_pc hold a real instruction.

Function
REQ-016 Fetch PC register increments by 4 on each handshake; wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 o_imem_addr SHALL equal fetch PC with bits [1:0] forced 0; held stable while o_imem_req=1 and i_imem_gnt=0.
REQ-018 o_imem_req SHALL be 1 only when outstanding + buffer_count < 2 (credit limit 2); never during reset.
REQ-019 Each granted request SHALL push its PC into a 2-entry in-order tag queue; each non-dropped response pops the tag and writes {inst,pc} into a 2-entry response buffer.
REQ-020 When i_stall=0: buffer non-empty -> pop head into or_inst/or_pc, or_valid=1 next cycle; buffer empty -> or_inst=NOP_INST, or_valid=0, or_pc unchanged.
REQ-021 When i_stall=1 and i_flush=0: or_inst/or_pc/or_valid hold; responses continue to fill buffer; credit rule stops issue.
REQ-022 Minimum latency: grant in cycle N, rvalid in N+1 -> or_valid=1 in N+2 (buffer write and pop may occur same cycle, bypass not required but allowed only if latency identical).
REQ-023 i_flush=1 SHALL take priority over i_stall: fetch PC <= {i_redirect_pc[31:2],2'b00}; response buffer and tag queue cleared; or_valid<=0, or_inst<=NOP_INST.
REQ-024 On flush, drop_cnt <= requests in flight (including one granted in the flush cycle, excluding a response accepted that cycle); next drop_cnt responses discarded without buffer write.
REQ-025 In the flush cycle o_imem_req SHALL be 0; issue from redirect address resumes the next cycle, subject to credit (drop_cnt counts against credit).
REQ-026 Simultaneous push and pop on a full buffer SHALL be legal; push to full without pop SHALL never occur (guaranteed by credit).
REQ-027 rvalid with no outstanding request is a protocol error; assertion only, no recovery.

Reset
REQ-028 On i_rst=1, asynchronously: fetch PC=RESET_PC, or_inst=NOP_INST, or_pc=0, or_valid=0, o_imem_req=0, buffers empty, outstanding=0, drop_cnt=0.
REQ-029 Reset mid-transaction SHALL abandon in-flight requests; memory is reset together with fetch.
REQ-030 First request SHALL issue in the first cycle after i_rst deasserts.

Structure
REQ-031 XLEN, NOP encoding and RESET_PC default SHALL come from the shared header/package used by decode.
REQ-032 One sub-module, fetch_fifo (parameterised depth 2, width 64), SHALL implement the response buffer; tag queue may reuse it at width 32.

Verification
REQ-033 Reset release, gnt=1, rvalid one cycle later, rdata=addr -> or_pc 0,4,8... consecutive cycles, or_valid=1 from cycle 3.
REQ-034 i_stall=1 for 4 cycles at or_pc=8 -> or_pc held 8, max 2 requests outstanding, after release or_pc=12,16 with no gap or loss.
REQ-035 i_flush with redirect 32'h0000_0103 while 2 in flight -> two responses dropped, next or_pc=32'h0000_0100.
REQ-036 i_flush and i_stall together -> flush wins, or_valid=0, or_inst=32'h0000_0013.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> or_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 i_rst asserted with 2 outstanding, gnt held 0 three cycles -> all outputs at reset values, o_imem_addr=RESET_PC after release.
